pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter DATA_W, default 32, is the width of the datapath payload (PC, operands, immediate, ALU result).
REQ-002 Parameter CTRL_W, default 8, is the width of the control-signal bundle, which is forced to zero whenever the stage presents a bubble.
REQ-003 Parameter CNT_W, default 16, is the width of the stall-cycle counter.
REQ-004 Port clk_i, input, 1 bit, is the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_i, input, 1 bit, is the reset: asynchronous and active-high.
REQ-006 Port flush_i, input, 1 bit, is a synchronous kill of all held entries (branch mispredict or exception).
REQ-007 Port in_valid_i, input, 1 bit, indicates that the upstream stage offers an entry.
REQ-008 Port in_ready_o, output, 1 bit, indicates that the stage can accept an entry this cycle.
REQ-009 Port in_data_i, input, DATA_W bits, is the upstream payload.
REQ-010 Port in_ctrl_i, input, CTRL_W bits, is the upstream control bundle.
REQ-011 Port out_valid_o, output, 1 bit, indicates that the downstream entry is valid.
REQ-012 Port out_ready_i, input, 1 bit, indicates that the downstream stage accepts the entry this cycle.
REQ-013 Port out_data_o, output, DATA_W bits, is the downstream payload.
REQ-014 Port out_ctrl_o, output, CTRL_W bits, is the downstream control bundle; it SHALL be zero when out_valid_o=0.
REQ-015 Port stall_cnt_o, output, CNT_W bits, counts cycles with out_valid_o=1 and out_ready_i=0, saturating at its maximum.

Function
REQ-016 Definitions: in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
REQ-017 The FSM SHALL have three states: EMPTY (no entries), ONE (main entry valid), TWO (main and skid entries valid).
REQ-018 From EMPTY: if in_fire, the stage SHALL capture main from the input and go to ONE; otherwise it SHALL stay in EMPTY.
REQ-019 From ONE with in_fire and out_fire: main SHALL be loaded from the input and the state SHALL stay ONE.
REQ-020 From ONE with in_fire and no out_fire: skid SHALL be loaded from the input and the state SHALL go to TWO.
REQ-021 From ONE with out_fire and no in_fire: the state SHALL go to EMPTY.
REQ-022 From TWO with out_fire: main SHALL be loaded from skid and the state SHALL go to ONE; otherwise the state SHALL hold.
REQ-023 in_ready_o SHALL be 1 exactly when the state is not TWO, and SHALL be decoded from the registered state only, with no combinational path from out_ready_i.
REQ-024 out_valid_o SHALL be 1 exactly when the state is not EMPTY; out_data_o and out_ctrl_o SHALL be driven from main.
REQ-025 Latency from in_fire to out_valid_o SHALL be 1 cycle; sustained throughput with out_ready_i=1 SHALL be 1 entry per cycle.
REQ-026 Ordering SHALL be strict FIFO; no entry SHALL be duplicated or dropped except by flush.
REQ-027 When flush_i=1, the next state SHALL be EMPTY regardless of in_fire and out_fire; a simultaneous input entry SHALL be discarded.
REQ-028 On flush, out_ctrl_o SHALL read zero from the following cycle; out_data_o MAY retain stale data.
REQ-029 The stall counter SHALL increment by 1 per stalled cycle, hold at 2^CNT_W-1, and SHALL NOT be cleared by flush.

Reset
REQ-030 When rst_i is asserted, the state SHALL become EMPTY immediately and out_valid_o SHALL become 0.
REQ-031 During reset, in_ready_o SHALL be 1, out_ctrl_o SHALL be 0, out_data_o SHALL be 0, and stall_cnt_o SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard both entries with no output glitch to a valid state.
REQ-033 Normal operation SHALL resume on the first rising clock edge after rst_i deasserts.

Structure
REQ-034 The state enum (EMPTY, ONE, TWO) and the default widths SHALL reside in the shared package pipe_pkg.
REQ-035 The saturating counter SHALL be a separate sub-module, pipe_sat_ctr, parameterised by CNT_W, with inc_i and clear-on-reset.
REQ-036 The main and skid entries SHALL each be a DATA_W+CTRL_W register; there SHALL be no other storage.

Verification
REQ-037 Reset, then in_valid=1 with data=0x00000010, ctrl=0x81, and out_ready=1 -> next cycle out_valid=1, data=0x10, ctrl=0x81.
REQ-038 Stream 0x1..0x8 with out_ready=1 continuously -> outputs 0x1..0x8 on consecutive cycles and in_ready constant at 1.
REQ-039 Stream 0xA, 0xB, then drop out_ready for 3 cycles -> state TWO, in_ready=0, out_data held at 0xA, stall_cnt=3; on release, 0xA then 0xB are delivered.
REQ-040 In state TWO, pulse flush_i together with in_valid=1 and data=0xC -> next cycle out_valid=0, out_ctrl=0, in_ready=1, and 0xC is never delivered.
REQ-041 With CNT_W=4 and out_ready held low for 20 cycles -> stall_cnt_o saturates at 15.
REQ-042 Assert rst_i asynchronously mid-cycle while in TWO -> out_valid=0 and stall_cnt=0 before the next clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline skid stage: default datapath, control
// and stall-counter widths, and the occupancy state encoding.
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  // Occupancy of the stage: nothing held, main entry only, main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

endpackage : pipe_pkg

// File: rtl/pipe_sat_ctr.sv
// ---------------------------------------------------------------------------
// pipe_sat_ctr
// Saturating up-counter. Increments by one on each clock where inc_i is high
// and sticks at its all-ones value. Cleared only by the asynchronous reset.
//
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-high reset, clears the count
//   inc_i  - increment request for this cycle
//   cnt_o  - current count (CNT_W bits)
// ---------------------------------------------------------------------------
module pipe_sat_ctr
  import pipe_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_STEP = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;

  // Stop at the maximum so a long stall never wraps back to a small value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_STEP;
    end
  end

  assign cnt_o = cnt_q;

endmodule : pipe_sat_ctr

// File: rtl/pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage
// Two-entry valid/ready pipeline register with a skid buffer. in_ready_o is
// decoded from registered state only, so there is no combinational path from
// out_ready_i back to the upstream stage. Entries leave in strict FIFO order.
// A flush kills both held entries; the control bundle reads zero whenever no
// valid entry is presented. Cycles where the output is valid but not accepted
// are counted in a saturating stall counter that survives flushes.
//
// Ports:
//   clk_i        - clock, rising edge
//   rst_i        - asynchronous active-high reset
//   flush_i      - synchronous kill of all held entries
//   in_valid_i   - upstream offers an entry
//   in_ready_o   - stage can accept an entry this cycle
//   in_data_i    - upstream payload (DATA_W)
//   in_ctrl_i    - upstream control bundle (CTRL_W)
//   out_valid_o  - downstream entry valid
//   out_ready_i  - downstream accepts the entry this cycle
//   out_data_o   - downstream payload (DATA_W)
//   out_ctrl_o   - downstream control bundle, zero when not valid (CTRL_W)
//   stall_cnt_o  - saturating count of stalled output cycles (CNT_W)
// ---------------------------------------------------------------------------
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int ENTRY_W = DATA_W + CTRL_W;

  skid_state_e        state_q, state_d;
  logic [ENTRY_W-1:0] main_q;
  logic [ENTRY_W-1:0] skid_q;
  logic [ENTRY_W-1:0] in_entry;

  logic in_fire;
  logic out_fire;
  logic main_from_in;
  logic main_from_skid;
  logic skid_from_in;

  // Entries are stored as {ctrl, data}.
  assign in_entry = {in_ctrl_i, in_data_i};

  assign in_ready_o  = (state_q != TWO);
  assign out_valid_o = (state_q != EMPTY);
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and register-load decode. The skid entry is only filled when
  // main is occupied and cannot drain, which is what keeps ordering FIFO.
  // Flush overrides everything so a same-cycle input entry is dropped.
  always_comb begin
    state_d        = state_q;
    main_from_in   = 1'b0;
    main_from_skid = 1'b0;
    skid_from_in   = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_from_in = 1'b1;
          state_d      = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_from_in = 1'b1;
        end else if (in_fire) begin
          skid_from_in = 1'b1;
          state_d      = TWO;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          main_from_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    if (flush_i) begin
      state_d        = EMPTY;
      main_from_in   = 1'b0;
      main_from_skid = 1'b0;
      skid_from_in   = 1'b0;
    end
  end

  // Entry storage. Payload is left untouched on flush; only the state marks
  // the entries dead, and the control bundle is masked at the output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_from_in) begin
        main_q <= in_entry;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (skid_from_in) begin
        skid_q <= in_entry;
      end
    end
  end

  assign out_data_o = main_q[DATA_W-1:0];
  assign out_ctrl_o = out_valid_o ? main_q[ENTRY_W-1:DATA_W] : '0;

  pipe_sat_ctr #(
    .CNT_W (CNT_W)
  ) u_stall_ctr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (out_valid_o & ~out_ready_i),
    .cnt_o (stall_cnt_o)
  );

endmodule : pipe_skid_stage

// File: tb/tb_pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_stage
// Self-checking bench for pipe_skid_stage. A capacity-two queue model tracks
// what the stage must present each cycle; a negedge process compares the DUT
// against it, and directed scenarios pin literal values. A second instance
// with a 4-bit stall counter shares the stimulus to exercise saturation.
// ---------------------------------------------------------------------------
module tb_pipe_skid_stage;

  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          out_ready = 1'b0;

  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [15:0]   stall_cnt;

  logic          in_ready_s;
  logic          out_valid_s;
  logic [DW-1:0] out_data_s;
  logic [CW-1:0] out_ctrl_s;
  logic [3:0]    stall_cnt_s;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_ctrl_i   (in_ctrl),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_ctrl_o  (out_ctrl),
    .stall_cnt_o (stall_cnt)
  );

  pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4)) dut_small (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready_s),
    .in_data_i   (in_data),
    .in_ctrl_i   (in_ctrl),
    .out_valid_o (out_valid_s),
    .out_ready_i (out_ready),
    .out_data_o  (out_data_s),
    .out_ctrl_o  (out_ctrl_s),
    .stall_cnt_o (stall_cnt_s)
  );

  // Reference model: an ordered queue holding at most two entries.
  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
  } entry_t;

  entry_t      mq[$];
  int unsigned m_cnt       = 0;
  int unsigned m_cnt_small = 0;
  bit          m_in_rdy;
  bit          m_out_vld;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_cnt       = 0;
      m_cnt_small = 0;
    end else begin
      m_in_rdy  = (mq.size() < 2);
      m_out_vld = (mq.size() > 0);
      if (m_out_vld && !out_ready) begin
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (m_cnt_small < 15) m_cnt_small = m_cnt_small + 1;
      end
      if (flush) begin
        mq.delete();
      end else begin
        if (m_out_vld && out_ready) void'(mq.pop_front());
        if (in_valid && m_in_rdy) mq.push_back('{data: in_data, ctrl: in_ctrl});
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst_in_ready",  64'(in_ready),    64'd1);
      checkOutput("rst_out_valid", 64'(out_valid),   64'd0);
      checkOutput("rst_out_data",  64'(out_data),    64'd0);
      checkOutput("rst_out_ctrl",  64'(out_ctrl),    64'd0);
      checkOutput("rst_stall_cnt", 64'(stall_cnt),   64'd0);
      checkOutput("rst_stall_sm",  64'(stall_cnt_s), 64'd0);
    end else begin
      checkOutput("mdl_in_ready",  64'(in_ready),  64'(mq.size() < 2));
      checkOutput("mdl_out_valid", 64'(out_valid), 64'(mq.size() > 0));
      checkOutput("mdl_out_ctrl",  64'(out_ctrl),  (mq.size() > 0) ? 64'(mq[0].ctrl) : 64'd0);
      if (mq.size() > 0) begin
        checkOutput("mdl_out_data", 64'(out_data), 64'(mq[0].data));
      end
      checkOutput("mdl_stall_cnt", 64'(stall_cnt),   64'(m_cnt));
      checkOutput("mdl_stall_sm",  64'(stall_cnt_s), 64'(m_cnt_small));
      checkOutput("mdl_out_valid_sm", 64'(out_valid_s), 64'(mq.size() > 0));
    end
  end

  // Drive one cycle of inputs; returns 2 time units after the consuming edge.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                               input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_in_ready",  64'(in_ready),  64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_data",  64'(out_data),  64'd0);
    checkOutput("reset_stall",     64'(stall_cnt), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #2;

    // Single entry with one-cycle latency.
    applyStimulus(1'b1, 32'h10, 8'h81, 1'b1, 1'b0);
    checkOutput("first_valid", 64'(out_valid), 64'd1);
    checkOutput("first_data",  64'(out_data),  64'h10);
    checkOutput("first_ctrl",  64'(out_ctrl),  64'h81);
    applyStimulus(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    checkOutput("drain_valid", 64'(out_valid), 64'd0);
    checkOutput("drain_ctrl",  64'(out_ctrl),  64'd0);

    // Back-to-back stream at full throughput.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 32'(i), 8'(i + 32), 1'b1, 1'b0);
      checkOutput("stream_valid", 64'(out_valid), 64'd1);
      checkOutput("stream_data",  64'(out_data),  64'(i));
      checkOutput("stream_ready", 64'(in_ready),  64'd1);
    end
    applyStimulus(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    checkOutput("stream_end_valid", 64'(out_valid), 64'd0);

    // Fill the skid buffer while downstream stalls for three cycles.
    applyStimulus(1'b1, 32'hA, 8'h0A, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'hB, 8'h0B, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    checkOutput("skid_in_ready", 64'(in_ready),  64'd0);
    checkOutput("skid_valid",    64'(out_valid), 64'd1);
    checkOutput("skid_hold_a",   64'(out_data),  64'hA);
    checkOutput("skid_stall3",   64'(stall_cnt), 64'd3);
    applyStimulus(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    checkOutput("release_b",     64'(out_data),  64'hB);
    checkOutput("release_ctrl",  64'(out_ctrl),  64'h0B);
    applyStimulus(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    checkOutput("release_empty", 64'(out_valid), 64'd0);

    // Flush while full, with a simultaneous input that must be dropped.
    applyStimulus(1'b1, 32'h21, 8'h21, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h22, 8'h22, 1'b0, 1'b0);
    checkOutput("pre_flush_full", 64'(in_ready), 64'd0);
    applyStimulus(1'b1, 32'hC, 8'h0C, 1'b0, 1'b1);
    checkOutput("flush_valid",    64'(out_valid), 64'd0);
    checkOutput("flush_ctrl",     64'(out_ctrl),  64'd0);
    checkOutput("flush_in_ready", 64'(in_ready),  64'd1);
    checkOutput("flush_keep_cnt", 64'(stall_cnt), 64'd5);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
      checkOutput("flush_no_c", 64'(out_valid), 64'd0);
    end

    // Long stall: the 4-bit counter saturates, the 16-bit one keeps going.
    doReset();
    applyStimulus(1'b1, 32'h77, 8'h77, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
    end
    checkOutput("sat_small", 64'(stall_cnt_s), 64'd15);
    checkOutput("sat_big",   64'(stall_cnt),   64'd20);
    checkOutput("sat_data",  64'(out_data),    64'h77);

    // Asynchronous reset mid-cycle while full.
    applyStimulus(1'b1, 32'h78, 8'h78, 1'b0, 1'b0);
    checkOutput("pre_arst_full", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #1;
    checkOutput("arst_valid",    64'(out_valid),   64'd0);
    checkOutput("arst_stall",    64'(stall_cnt),   64'd0);
    checkOutput("arst_stall_sm", 64'(stall_cnt_s), 64'd0);
    checkOutput("arst_in_ready", 64'(in_ready),    64'd1);
    checkOutput("arst_ctrl",     64'(out_ctrl),    64'd0);
    checkOutput("arst_data",     64'(out_data),    64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #2;

    // Operation resumes after reset release.
    applyStimulus(1'b1, 32'h55, 8'h05, 1'b1, 1'b0);
    checkOutput("resume_valid", 64'(out_valid), 64'd1);
    checkOutput("resume_data",  64'(out_data),  64'h55);
    checkOutput("resume_ctrl",  64'(out_ctrl),  64'h05);
    applyStimulus(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
    checkOutput("resume_drain", 64'(out_valid), 64'd0);

    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_pipe_skid_stage
